// File: rtl/uart_rom_loader_pkg.sv
// Shared constants, state encodings and helpers for the UART ROM download engine.
package uart_rom_loader_pkg;

    localparam int unsigned MEM_BUS_W  = 32;
    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned ROM_NUM    = 4096;
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Byte address of ROM word idx relative to base.
    function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [MEM_ADDR_W-1:0] base,
                                                        input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_rom_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, byte_vld/frame_err pulses.
module uart_rom_loader_rx
    import uart_rom_loader_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_byte_vld,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

    // [1:0] synchroniser, [2] previous synchronised value for edge detection
    logic [2:0]       r_sync;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    logic w_rx;
    logic w_fall;
    assign w_rx   = r_sync[1];
    assign w_fall = r_sync[2] & ~r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 3'b111;
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            o_byte_vld  <= 1'b0;
            o_byte      <= '0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[1:0], i_rx};
            o_byte_vld  <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                        else               r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (w_rx) begin
                            o_byte_vld <= 1'b1;
                            o_byte     <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rom_loader.sv
// UART download engine: parses sync/length/data/checksum frames and writes words to the ROM.
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int unsigned           CLK_FREQ    = 50_000_000,
    parameter int unsigned           BAUD        = 115200,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = 32'h0,
    parameter int unsigned           ROM_WORDS   = ROM_NUM,
    parameter int unsigned           TIMEOUT_CYC = (CLK_FREQ / BAUD) * 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx_i,
    output logic                  rom_we_o,
    output logic [MEM_ADDR_W-1:0] rom_addr_o,
    output logic [MEM_BUS_W-1:0]  rom_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned      DIV     = CLK_FREQ / BAUD;
    localparam int unsigned      GAP_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC);

    logic       w_byte_vld;
    logic [7:0] w_byte;
    logic       w_frame_err;

    uart_rom_loader_rx #(.DIV(DIV)) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (uart_rx_i),
        .o_byte_vld (w_byte_vld),
        .o_byte     (w_byte),
        .o_frame_err(w_frame_err)
    );

    load_state_t          r_state;
    logic [15:0]          r_len;
    logic [15:0]          r_idx;
    logic [1:0]           r_bcnt;
    logic [MEM_BUS_W-1:0] r_word;
    logic [7:0]           r_sum;
    logic [GAP_W-1:0]     r_gap;

    logic                 w_timeout;
    logic [15:0]          w_len_n;
    logic [MEM_BUS_W-1:0] w_word_next;

    assign w_timeout   = (r_state != ST_IDLE) && (r_gap == GAP_MAX);
    assign w_len_n     = {w_byte, r_len[7:0]};
    assign w_word_next = {w_byte, r_word[MEM_BUS_W-1:8]};

    // Inter-byte gap counter; only runs inside a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (r_state == ST_IDLE || w_byte_vld) begin
            r_gap <= '0;
        end else if (!w_timeout) begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    // Timeout takes priority over a byte landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_word     <= '0;
            r_sum      <= '0;
            rom_we_o   <= 1'b0;
            rom_addr_o <= '0;
            rom_data_o <= '0;
            cpu_hold_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rom_we_o <= 1'b0;
            done_o   <= 1'b0;
            if (w_timeout || w_frame_err) begin
                err_o      <= 1'b1;
                cpu_hold_o <= 1'b0;
                busy_o     <= 1'b0;
                r_state    <= ST_IDLE;
            end else if (w_byte_vld) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_sum      <= '0;
                            r_bcnt     <= '0;
                            r_idx      <= '0;
                            err_o      <= 1'b0;
                            cpu_hold_o <= 1'b1;
                            busy_o     <= 1'b1;
                            r_state    <= ST_LEN0;
                        end
                    end
                    ST_LEN0: begin
                        r_len[7:0] <= w_byte;
                        r_state    <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        r_len <= w_len_n;
                        if (32'(w_len_n) > ROM_WORDS) begin
                            err_o      <= 1'b1;
                            cpu_hold_o <= 1'b0;
                            busy_o     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else if (w_len_n == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_word <= w_word_next;
                        r_sum  <= r_sum + w_byte;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            rom_we_o   <= 1'b1;
                            rom_addr_o <= word_addr(BASE_ADDR, r_idx);
                            rom_data_o <= w_word_next;
                            r_idx      <= r_idx + 16'd1;
                            if (r_idx + 16'd1 == r_len) r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (w_byte == r_sum) done_o <= 1'b1;
                        else                 err_o  <= 1'b1;
                        cpu_hold_o <= 1'b0;
                        busy_o     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
